pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the IF stage of the pipelined core; successor to the fixed 32-bit stall-only PC register. Adds configurable width, reset and trap vectors, prioritised redirects (trap, branch, return prediction), a pending-redirect latch so a redirect arriving during a stall is never lost, and a circular return-address stack (RAS). Its output `pc` drives instruction-memory address and the IF/ID pipeline register.

## Interface
- `XLEN`, 32: address width.
- `RESET_VEC`, 32'h0000_0000: PC after reset.
- `TRAP_VEC`, 32'h0000_0100: redirect target on `trap`.
- `INC`, 4: sequential increment (bytes).
- `RAS_DEPTH`, 4: RAS entries, power of two, ≥2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold `pc` this cycle (hazard unit).
- `trap`  in  1  exception redirect to `TRAP_VEC`.
- `br_taken`  in  1  EX-stage branch/jump redirect.
- `br_target`  in  XLEN  target for `br_taken`.
- `ras_push`  in  1  ID decoded a call; push `ras_push_addr`.
- `ras_push_addr`  in  XLEN  return address to push.
- `ras_pop`  in  1  ID decoded a return; pop and redirect.
- `pc`  out  XLEN  current fetch address.
- `pc_valid`  out  1  `pc` is a real fetch address.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  occupied RAS entries.
- `ras_empty`  out  1  `ras_count == 0`.

## Operation
- Redirect source priority per cycle: `trap` > `br_taken` > `ras_pop` (only when RAS non-empty) > none. Winning target = `TRAP_VEC` / `br_target` / RAS top.
- Next-PC selection when not stalled: winning redirect this cycle, else pending redirect, else `pc + INC` (mod 2^XLEN, wrap silently).
- When `stall`=1: `pc` holds. Any redirect this cycle is written into the pending latch (`pend_vld`, `pend_pc`). A new redirect overwrites an existing pending one, except that a pending trap is only overwritten by another trap.
- Pending latch clears on the first non-stalled edge that consumes it, or when a non-stalled redirect is taken that same edge (the fresh redirect wins).
- RAS: circular buffer, top pointer wraps mod `RAS_DEPTH`.
  - Push: write at top+1, advance top, `ras_count` saturates at `RAS_DEPTH`; push when full overwrites oldest entry.
  - Pop on empty: ignored, no redirect, count stays 0.
  - Push+pop same cycle: redirect target = old top; new address written in its slot; pointer and count unchanged.
  - RAS updates occur regardless of `stall`; upstream gates push/pop to once per instruction.
  - `trap` and `br_taken` do not repair the RAS.

## Timing
- Reset (`rst_n`=0, asynchronous): `pc`=`RESET_VEC`, `pc_valid`=0, `pend_vld`=0, `ras_count`=0, `ras_empty`=1, top pointer 0. RAS contents are don't-care.
- First rising edge after `rst_n` rises: `pc_valid`←1, `pc` stays `RESET_VEC`. Increments begin on the following edge. `stall` is ignored on this edge.
- Redirect latency: 1 cycle. A redirect asserted in cycle n gives `pc`=target after edge n when not stalled, or after the first non-stalled edge.
- `ras_count`/`ras_empty` update on the same edge as push/pop.
- Reset asserted mid-operation discards pending redirect and RAS state immediately.

## Structure
- Shared package `pc_pkg`: `XLEN` default, `RESET_VEC`/`TRAP_VEC` defaults, and enum `redir_src_t` {NONE, RAS, BR, TRAP}, used both for the pending-overwrite rule and by the testbench.
- Sub-module `pc_ras`: storage, pointer, count, push/pop/overwrite rules. Exports top entry and empty flag.
- `pc_gen` holds the priority mux, pending latch and PC register.

## Test plan
- Reset release, no stall: `pc` = 0x0, 0x0 (`pc_valid` 0→1), then 0x4, 0x8, 0xC on successive edges.
- `br_taken`=1, `br_target`=0x40 at `pc`=0x8, with `trap`=1 the same cycle: next `pc`=0x100. Repeat without `trap`: next `pc`=0x40.
- `stall`=1 for 3 cycles at `pc`=0x10 with `br_taken` (target 0x80) pulsed in stall cycle 1: `pc` holds 0x10 throughout, becomes 0x80 on the first unstalled edge, then 0x84.
- `RAS_DEPTH`=4: push 0x100, 0x104, 0x108, 0x10C, 0x110. `ras_count` saturates at 4. Four pops redirect to 0x110, 0x10C, 0x108, 0x104. A fifth pop gives no redirect, `pc` increments, `ras_empty`=1.
- Simultaneous push 0x200 and pop with top=0x50: `pc`→0x50, `ras_count` unchanged. The next pop redirects to 0x200.
- Assert `rst_n`=0 mid-stall with a pending redirect: `pc`=`RESET_VEC` immediately and `pc_valid`=0. After release, no stale redirect is taken.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the IF-stage program-counter generator.
// Redirect source ordering doubles as the priority used by the pending latch.
package pc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RAS  = 2'd1,
        BR   = 2'd2,
        TRAP = 2'd3
    } redir_src_t;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } pc_state_t;

    // A parked trap may only be displaced by another trap.
    function automatic logic canOverwrite(input redir_src_t pendSrc, input redir_src_t freshSrc);
        return (freshSrc != NONE) && ((pendSrc != TRAP) || (freshSrc == TRAP));
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the hazard/decode/EX logic and pc_gen.
// The master side drives redirect and RAS requests; pc_gen is the slave.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            stall;
    logic            trap;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            ras_push;
    logic [XLEN-1:0] ras_push_addr;
    logic            ras_pop;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [CW-1:0]   ras_count;
    logic            ras_empty;

    modport master (
        output stall, trap, br_taken, br_target, ras_push, ras_push_addr, ras_pop,
        input  pc, pc_valid, ras_count, ras_empty
    );

    modport slave (
        input  stall, trap, br_taken, br_target, ras_push, ras_push_addr, ras_pop,
        output pc, pc_valid, ras_count, ras_empty
    );

endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: the newest entry always sits at the top pointer,
// and pushing into a full stack silently drops the oldest entry.
module pc_ras #(
    parameter  int XLEN      = 32,
    parameter  int RAS_DEPTH = 4,
    localparam int PW        = $clog2(RAS_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] pushAddr_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic [CW-1:0]   count_o,
    output logic            popValid_o
);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   topPtr_q, topPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wrPtr;
    logic            wrEn;
    logic            doPop;

    assign empty_o    = (count_q == '0);
    assign doPop      = pop_i && !empty_o;
    assign popValid_o = doPop;
    assign top_o      = mem_q[topPtr_q];
    assign count_o    = count_q;

    // Push+pop replaces the top in place, so the call/return pair leaves depth unchanged.
    always_comb begin
        topPtr_d = topPtr_q;
        count_d  = count_q;
        wrPtr    = topPtr_q;
        wrEn     = 1'b0;
        if (push_i && doPop) begin
            wrEn = 1'b1;
        end else if (push_i) begin
            wrEn     = 1'b1;
            wrPtr    = topPtr_q + 1'b1;
            topPtr_d = topPtr_q + 1'b1;
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (doPop) begin
            topPtr_d = topPtr_q - 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            topPtr_q <= '0;
            count_q  <= '0;
        end else begin
            topPtr_q <= topPtr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr] <= pushAddr_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: prioritised redirects, a pending latch that keeps
// redirects arriving during stalls, and a return-address stack for predictions.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.slave  bus
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    pc_state_t       state_q, state_d;
    logic            running;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pendPc_q, pendPc_d;
    redir_src_t      pendSrc_q, pendSrc_d;
    logic            pendVld;
    redir_src_t      src;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] rasTop;
    logic            rasEmpty;
    logic            rasPopValid;
    logic [CW-1:0]   rasCount;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) uRas (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (bus.ras_push),
        .pop_i      (bus.ras_pop),
        .pushAddr_i (bus.ras_push_addr),
        .top_o      (rasTop),
        .empty_o    (rasEmpty),
        .count_o    (rasCount),
        .popValid_o (rasPopValid)
    );

    always_comb begin
        src    = NONE;
        target = pc_q;
        if (bus.trap) begin
            src    = TRAP;
            target = TRAP_VEC;
        end else if (bus.br_taken) begin
            src    = BR;
            target = bus.br_target;
        end else if (rasPopValid) begin
            src    = RAS;
            target = rasTop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    assign pendVld = (pendSrc_q != NONE);

    // The first edge out of reset only raises pc_valid, so it parks redirects like a stall.
    always_comb begin
        pc_d      = pc_q;
        pendSrc_d = pendSrc_q;
        pendPc_d  = pendPc_q;
        if (running && !bus.stall) begin
            pendSrc_d = NONE;
            if (src != NONE) begin
                pc_d = target;
            end else if (pendVld) begin
                pc_d = pendPc_q;
            end else begin
                pc_d = pc_q + XLEN'(INC);
            end
        end else if (canOverwrite(pendSrc_q, src)) begin
            pendSrc_d = src;
            pendPc_d  = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            pendSrc_q <= NONE;
            pendPc_q  <= RESET_VEC;
        end else begin
            pc_q      <= pc_d;
            pendSrc_q <= pendSrc_d;
            pendPc_q  <= pendPc_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = running;
    assign bus.ras_count = rasCount;
    assign bus.ras_empty = rasEmpty;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed vector table for the documented
// scenarios, a mid-stall reset sequence, then random traffic against a queue-based model.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .INC       (4),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        trap;
        logic        br;
        logic [31:0] tgt;
        logic        push;
        logic [31:0] paddr;
        logic        pop;
        logic [31:0] expPc;
        int          expCount;
    } vec_t;

    vec_t vecs[$];

    // Reference model: architectural PC, one parked redirect, RAS as a plain queue (newest at back).
    logic [31:0] mPc;
    bit          mValid;
    redir_src_t  mPendSrc;
    logic [31:0] mPendPc;
    logic [31:0] mRas[$];

    function automatic vec_t mk(input bit s, input bit t, input bit b, input logic [31:0] tg,
                                input bit pu, input logic [31:0] pa, input bit po,
                                input logic [31:0] ep, input int ec);
        vec_t v;
        v.stall = s; v.trap = t; v.br = b; v.tgt = tg;
        v.push = pu; v.paddr = pa; v.pop = po;
        v.expPc = ep; v.expCount = ec;
        return v;
    endfunction

    task automatic modelReset();
        mPc      = 32'h0;
        mValid   = 1'b0;
        mPendSrc = NONE;
        mPendPc  = 32'h0;
        mRas.delete();
    endtask

    task automatic modelStep(input bit s, input bit t, input bit b, input logic [31:0] tg,
                             input bit pu, input logic [31:0] pa, input bit po);
        bit          popOk;
        redir_src_t  src;
        logic [31:0] tgtPc;
        popOk = po && (mRas.size() > 0);
        src   = NONE;
        tgtPc = mPc;
        if (t) begin
            src = TRAP; tgtPc = 32'h100;
        end else if (b) begin
            src = BR; tgtPc = tg;
        end else if (popOk) begin
            src = RAS; tgtPc = mRas[mRas.size()-1];
        end
        if (pu && popOk) begin
            mRas[mRas.size()-1] = pa;
        end else if (pu) begin
            mRas.push_back(pa);
            if (mRas.size() > DEPTH) void'(mRas.pop_front());
        end else if (popOk) begin
            void'(mRas.pop_back());
        end
        if (!mValid) begin
            mValid = 1'b1;
        end else if (s) begin
            if (src != NONE && (mPendSrc != TRAP || src == TRAP)) begin
                mPendSrc = src;
                mPendPc  = tgtPc;
            end
        end else begin
            if (src != NONE)           mPc = tgtPc;
            else if (mPendSrc != NONE) mPc = mPendPc;
            else                       mPc = mPc + 32'd4;
            mPendSrc = NONE;
        end
    endtask

    // Drives one cycle of inputs, advances the model, then samples 1 time unit after the edge.
    task automatic applyStimulus(input bit s, input bit t, input bit b, input logic [31:0] tg,
                                 input bit pu, input logic [31:0] pa, input bit po);
        bus.stall         = s;
        bus.trap          = t;
        bus.br_taken      = b;
        bus.br_target     = tg;
        bus.ras_push      = pu;
        bus.ras_push_addr = pa;
        bus.ras_pop       = po;
        modelStep(s, t, b, tg, pu, pa, po);
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ePc, input bit eValid, input int eCount);
        checkField({name, ".pc"}, bus.pc, ePc);
        checkField({name, ".pc_valid"}, 32'(bus.pc_valid), 32'(eValid));
        checkField({name, ".ras_count"}, 32'(bus.ras_count), 32'(eCount));
        checkField({name, ".ras_empty"}, 32'(bus.ras_empty), 32'(eCount == 0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.stall = 0; bus.trap = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.ras_push = 0; bus.ras_push_addr = '0; bus.ras_pop = 0;
        modelReset();

        // Sequential fetch, trap priority, stall with a parked branch, parked trap protection.
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h000,0));
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h004,0));
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h008,0));
        vecs.push_back(mk(0,1,1,32'h40, 0,32'h0,0, 32'h100,0));
        vecs.push_back(mk(0,0,1,32'h8,  0,32'h0,0, 32'h008,0));
        vecs.push_back(mk(0,0,1,32'h40, 0,32'h0,0, 32'h040,0));
        vecs.push_back(mk(0,0,1,32'h10, 0,32'h0,0, 32'h010,0));
        vecs.push_back(mk(1,0,1,32'h80, 0,32'h0,0, 32'h010,0));
        vecs.push_back(mk(1,0,0,32'h0,  0,32'h0,0, 32'h010,0));
        vecs.push_back(mk(1,0,0,32'h0,  0,32'h0,0, 32'h010,0));
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h080,0));
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h084,0));
        vecs.push_back(mk(1,1,0,32'h0,  0,32'h0,0, 32'h084,0));
        vecs.push_back(mk(1,0,1,32'h300,0,32'h0,0, 32'h084,0));
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h100,0));
        vecs.push_back(mk(1,0,1,32'h300,0,32'h0,0, 32'h100,0));
        vecs.push_back(mk(0,0,1,32'h500,0,32'h0,0, 32'h500,0));
        vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,0, 32'h504,0));
        // RAS saturation, overwrite of oldest, ignored pop on empty, push+pop swap.
        vecs.push_back(mk(0,0,0,32'h0,1,32'h100,0, 32'h508,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h104,0, 32'h50C,2));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h108,0, 32'h510,3));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h10C,0, 32'h514,4));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h110,0, 32'h518,4));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  1, 32'h110,3));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  1, 32'h10C,2));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  1, 32'h108,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  1, 32'h104,0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  1, 32'h108,0));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h50, 0, 32'h10C,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h200,1, 32'h050,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  1, 32'h200,0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,  0, 32'h204,0));

        #1 rst_n = 1'b0;
        #10;
        checkOutput("reset", 32'h0, 1'b0, 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, vecs[i].trap, vecs[i].br, vecs[i].tgt,
                          vecs[i].push, vecs[i].paddr, vecs[i].pop);
            checkOutput($sformatf("vec%0d", i), vecs[i].expPc, 1'b1, vecs[i].expCount);
        end

        // Reset in the middle of a stall must drop both the parked branch and the RAS.
        applyStimulus(1, 0, 1, 32'h700, 1, 32'h60, 0);
        checkOutput("stallPend", 32'h204, 1'b1, 1);
        bus.stall = 1; bus.br_taken = 0; bus.ras_push = 0;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midReset", 32'h0, 1'b0, 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("postReset0", 32'h0, 1'b1, 0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("postReset1", 32'h4, 1'b1, 0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("postReset2", 32'h8, 1'b1, 0);

        // Random traffic against the model.
        rst_n = 1'b0;
        #2;
        modelReset();
        checkOutput("rndReset", mPc, mValid, mRas.size());
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("rndFirst", mPc, mValid, mRas.size());
        for (int n = 0; n < 600; n++) begin
            bit          s, t, b, pu, po;
            logic [31:0] tg, pa;
            s  = ($urandom_range(0, 99) < 30);
            t  = ($urandom_range(0, 99) < 5);
            b  = ($urandom_range(0, 99) < 15);
            pu = ($urandom_range(0, 99) < 25);
            po = ($urandom_range(0, 99) < 25);
            tg = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            pa = {20'h1, 10'($urandom_range(0, 1023)), 2'b00};
            applyStimulus(s, t, b, tg, pu, pa, po);
            checkOutput($sformatf("rand%0d", n), mPc, mValid, mRas.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
